// File: rtl/eer_pkg.sv
// Shared definitions for the EER-RL RX packet parser: packet type codes,
// per-type word counts (with and without trailing checksum word), the
// parser FSM state type, and the "no route yet" hop count.
package eer_pkg;

  localparam logic [3:0]  TYPE_HB      = 4'h1;
  localparam logic [3:0]  TYPE_CHA     = 4'h2;

  // Total words per packet, header included
  localparam int          HB_WORDS     = 4;
  localparam int          CHA_WORDS    = 3;
  localparam int          HB_WORDS_CS  = 5;
  localparam int          CHA_WORDS_CS = 4;

  localparam logic [15:0] HOPS_INF     = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIELDS,
    ST_COMMIT,
    ST_DROP
  } state_e;

endpackage

// File: rtl/eer_sat_counter.sv
// Saturating up-counter: counts inc_i pulses, holds at all-ones.
module eer_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: step by one unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  // Count register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/eer_rx_pkt_parser.sv
// EER-RL RX packet parser: consumes the 16-bit RX word stream, parses
// heartbeat (HB) and cluster-head announcement (CHA) packets, registers
// the fields used by myNodeInfo and strobes en_MNI once per committed
// packet. Malformed / unknown packets are counted in drop_cnt.
// Optional build macro: RX_CHECKSUM_EN adds a trailing XOR checksum word.
module eer_rx_pkt_parser #(
  parameter int         DATA_W     = 16,
  parameter logic [3:0] TYPE_HB    = eer_pkg::TYPE_HB,
  parameter logic [3:0] TYPE_CHA   = eer_pkg::TYPE_CHA,
  parameter int         DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [DATA_W-1:0]     rx_data,
  input  logic                  rx_sop,
  input  logic                  rx_eop,
  output logic [DATA_W-1:0]     e_max,
  output logic [DATA_W-1:0]     e_min,
  output logic [DATA_W-1:0]     hops,
  output logic [DATA_W-1:0]     ch_ID,
  output logic [DATA_W-1:0]     timeslot,
  output logic                  en_MNI,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  import eer_pkg::*;

  // Payload index of the final word of each packet type
`ifdef RX_CHECKSUM_EN
  localparam logic [1:0] HB_LAST  = 2'(HB_WORDS_CS - 2);
  localparam logic [1:0] CHA_LAST = 2'(CHA_WORDS_CS - 2);
`else
  localparam logic [1:0] HB_LAST  = 2'(HB_WORDS - 2);
  localparam logic [1:0] CHA_LAST = 2'(CHA_WORDS - 2);
`endif

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d, last_q, last_d;
  logic              is_hb_q, is_hb_d;
  logic [DATA_W-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [DATA_W-1:0] e_max_q, e_max_d, e_min_q, e_min_d, hops_q, hops_d;
  logic [DATA_W-1:0] ch_q, ch_d, ts_q, ts_d;
  logic [DATA_W-1:0] fld0, fld1, fld2, hops_inc;
  logic [3:0]        hdr_type;
  logic              hs, hdr_hb, hdr_known, drop_inc, commit;
`ifdef RX_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  assign rx_ready  = (state_q != ST_COMMIT);
  assign en_MNI    = (state_q == ST_COMMIT);
  assign hs        = rx_valid & rx_ready;
  assign hdr_type  = rx_data[DATA_W-1 -: 4];
  assign hdr_hb    = (hdr_type == TYPE_HB);
  assign hdr_known = hdr_hb | (hdr_type == TYPE_CHA);

  // Field view at commit time: the final word is still on rx_data
  assign fld0     = (idx_q == 2'd0) ? rx_data : sh0_q;
  assign fld1     = (idx_q == 2'd1) ? rx_data : sh1_q;
  assign fld2     = (idx_q == 2'd2) ? rx_data : sh2_q;
  assign hops_inc = (fld0 == '1) ? fld0 : fld0 + DATA_W'(1);

  // Packet FSM: header decode, field capture, length/checksum checks
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    is_hb_d  = is_hb_q;
    sh0_d    = sh0_q;
    sh1_d    = sh1_q;
    sh2_d    = sh2_q;
    drop_inc = 1'b0;
    commit   = 1'b0;
`ifdef RX_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    if (state_q == ST_COMMIT) begin
      state_d = ST_IDLE;
    end else if (hs && rx_sop) begin
      // New header; a packet still in FIELDS is aborted and counted
      if (state_q == ST_FIELDS) drop_inc = 1'b1;
      idx_d   = 2'd0;
      is_hb_d = hdr_hb;
      last_d  = hdr_hb ? HB_LAST : CHA_LAST;
`ifdef RX_CHECKSUM_EN
      csum_d  = rx_data;
`endif
      if (!hdr_known || rx_eop) begin
        state_d  = (hdr_known || rx_eop) ? ST_IDLE : ST_DROP;
        drop_inc = 1'b1;
      end else begin
        state_d  = ST_FIELDS;
      end
    end else if (hs && state_q == ST_DROP) begin
      if (rx_eop) state_d = ST_IDLE;
    end else if (hs && state_q == ST_FIELDS) begin
      case (idx_q)
        2'd0:    sh0_d = rx_data;
        2'd1:    sh1_d = rx_data;
        2'd2:    sh2_d = rx_data;
        default: ;
      endcase
`ifdef RX_CHECKSUM_EN
      csum_d = csum_q ^ rx_data;
`endif
      if (idx_q == last_q) begin
        if (!rx_eop) begin
          state_d  = ST_DROP;
          drop_inc = 1'b1;
        end
`ifdef RX_CHECKSUM_EN
        else if (rx_data != csum_q) begin
          state_d  = ST_IDLE;
          drop_inc = 1'b1;
        end
`endif
        else begin
          state_d = ST_COMMIT;
          commit  = 1'b1;
        end
      end else if (rx_eop) begin
        state_d  = ST_IDLE;
        drop_inc = 1'b1;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  // Output field updates on the edge entering COMMIT
  always_comb begin
    e_max_d = e_max_q;
    e_min_d = e_min_q;
    hops_d  = hops_q;
    ch_d    = ch_q;
    ts_d    = ts_q;
    if (commit) begin
      if (is_hb_q) begin
        e_max_d = fld1;
        e_min_d = fld2;
        if (hops_inc < hops_q) hops_d = hops_inc;
      end else begin
        ch_d = fld0;
        ts_d = fld1;
      end
    end
  end

  // State, shadow and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      is_hb_q <= 1'b0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      e_max_q <= '0;
      e_min_q <= '0;
      hops_q  <= '1;
      ch_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      is_hb_q <= is_hb_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      e_max_q <= e_max_d;
      e_min_q <= e_min_d;
      hops_q  <= hops_d;
      ch_q    <= ch_d;
      ts_q    <= ts_d;
    end
  end

`ifdef RX_CHECKSUM_EN
  // Running XOR of header and payload words
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  assign e_max    = e_max_q;
  assign e_min    = e_min_q;
  assign hops     = hops_q;
  assign ch_ID    = ch_q;
  assign timeslot = ts_q;

  eer_sat_counter #(.W(DROP_CNT_W)) u_drop_cnt (
    .clk   (clk),
    .nrst  (nrst),
    .inc_i (drop_inc),
    .cnt_o (drop_cnt)
  );

endmodule

// File: tb/tb_eer_rx_pkt_parser.sv
// Testbench for eer_rx_pkt_parser: packet-level reference model,
// directed scenarios plus randomized packet stream.
module tb_eer_rx_pkt_parser;

`ifdef RX_CHECKSUM_EN
  localparam bit CS   = 1'b1;
  localparam int NHB  = 5;
  localparam int NCHA = 4;
`else
  localparam bit CS   = 1'b0;
  localparam int NHB  = 4;
  localparam int NCHA = 3;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_sop = 1'b0;
  logic        rx_eop = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_ready, en_MNI;
  logic [15:0] e_max, e_min, hops, ch_ID, timeslot;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  eer_rx_pkt_parser dut (
    .clk(clk), .nrst(nrst), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_sop(rx_sop), .rx_eop(rx_eop),
    .e_max(e_max), .e_min(e_min), .hops(hops), .ch_ID(ch_ID),
    .timeslot(timeslot), .en_MNI(en_MNI), .drop_cnt(drop_cnt)
  );

  int checks = 0, errors = 0, pulses = 0, last_stalls = 0;

  // Reference model state
  logic [15:0] m_emax = '0, m_emin = '0, m_hops = 16'hFFFF, m_ch = '0, m_ts = '0;
  int          m_drop = 0, m_commits = 0;

  // Current packet to send
  logic [15:0] pq[$];
  bit          peop;

  always @(negedge clk) if (en_MNI) pulses++;

  function automatic bit pkt_ok();
    int n;
    logic [15:0] x;
    case (pq[0][15:12])
      4'h1:    n = NHB;
      4'h2:    n = NCHA;
      default: n = 0;
    endcase
    if (n == 0 || !peop || pq.size() != n) return 1'b0;
    if (CS) begin
      x = '0;
      for (int i = 0; i < n - 1; i++) x ^= pq[i];
      if (x !== pq[n-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [7:0] exp_drop();
    return (m_drop > 255) ? 8'hFF : 8'(m_drop);
  endfunction

  task automatic model_apply();
    logic [15:0] hp1;
    if (pq[0][15:12] == 4'h1) begin
      m_emax = pq[2];
      m_emin = pq[3];
      hp1 = (pq[1] == 16'hFFFF) ? 16'hFFFF : pq[1] + 16'd1;
      if (hp1 < m_hops) m_hops = hp1;
    end else begin
      m_ch = pq[1];
      m_ts = pq[2];
    end
    m_commits++;
  endtask

  task automatic mk_pkt(input logic [15:0] w0, w1, w2, w3, input int nw, input bit eop);
    logic [15:0] src[4];
    logic [15:0] x;
    src = '{w0, w1, w2, w3};
    x = '0;
    pq.delete();
    for (int i = 0; i < nw; i++) begin
      pq.push_back(src[i]);
      x ^= src[i];
    end
    if (CS) pq.push_back(x);
    peop = eop;
  endtask

  // Drive pq word by word honouring rx_ready, then check against the model
  task automatic send_pkt(input bit gaps, input bit quiet);
    int i = 0;
    int stalls = 0;
    bit acc, ok;
    ok = pkt_ok();
    while (i < pq.size() && stalls <= 8) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0;
        rx_data  = 16'($urandom);
        rx_sop   = 1'($urandom);
        rx_eop   = 1'($urandom);
        @(posedge clk);
      end else begin
        rx_valid = 1'b1;
        rx_data  = pq[i];
        rx_sop   = (i == 0);
        rx_eop   = peop && (i == pq.size() - 1);
        acc      = rx_ready;
        @(posedge clk);
        if (acc) i++;
        else stalls++;
      end
    end
    last_stalls = stalls;
    #1;
    rx_valid = 1'b0;
    rx_sop   = 1'b0;
    rx_eop   = 1'b0;
    if (quiet) return;
    checks++;
    if (stalls > 8) begin
      errors++;
      $display("FAIL handshake_timeout stalls=%0d limit=8", stalls);
      return;
    end
    if (ok) model_apply();
    else    m_drop++;
    checks++;
    if (en_MNI !== ok) begin
      errors++;
      $display("FAIL en_MNI got=%b exp=%b hdr=%h len=%0d", en_MNI, ok, pq[0], pq.size());
    end
    checks++;
    if ({e_max, e_min, hops, ch_ID, timeslot} !== {m_emax, m_emin, m_hops, m_ch, m_ts}) begin
      errors++;
      $display("FAIL fields got=%h/%h/%h/%h/%h exp=%h/%h/%h/%h/%h",
               e_max, e_min, hops, ch_ID, timeslot, m_emax, m_emin, m_hops, m_ch, m_ts);
    end
    if (ok) begin
      checks++;
      if (rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL commit_ready got=%b exp=0", rx_ready);
      end
    end
    if (peop) begin
      checks++;
      if (drop_cnt !== exp_drop()) begin
        errors++;
        $display("FAIL drop_cnt got=%0d exp=%0d", drop_cnt, exp_drop());
      end
    end
  endtask

  task automatic junk();
    @(negedge clk);
    rx_valid = 1'b1;
    rx_sop   = 1'b0;
    rx_eop   = 1'($urandom);
    rx_data  = 16'($urandom);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({e_max, e_min, hops, ch_ID, timeslot} !== {16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0}) begin
      errors++;
      $display("FAIL %s_fields got=%h/%h/%h/%h/%h exp=0/0/ffff/0/0", tag, e_max, e_min, hops, ch_ID, timeslot);
    end
    checks++;
    if ({drop_cnt, rx_ready, en_MNI} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s_ctrl got drop=%0d rdy=%b en=%b exp drop=0 rdy=1 en=0", tag, drop_cnt, rx_ready, en_MNI);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("idle");
  endtask

  task automatic test_hops_sat();
    mk_pkt(16'h1000, 16'hFFFF, 16'h0111, 16'h0022, 4, 1'b1);
    send_pkt(1'b0, 1'b0);
    checks++;
    if (hops !== 16'hFFFF) begin
      errors++;
      $display("FAIL hops_sat got=%h exp=ffff", hops);
    end
  endtask

  task automatic test_hb();
    mk_pkt(16'h1000, 16'h0002, 16'h0320, 16'h0040, 4, 1'b1);
    send_pkt(1'b0, 1'b0);
    checks++;
    if ({hops, e_max, e_min} !== {16'h0003, 16'h0320, 16'h0040}) begin
      errors++;
      $display("FAIL hb_first got=%h/%h/%h exp=0003/0320/0040", hops, e_max, e_min);
    end
    mk_pkt(16'h1ABC, 16'h0005, 16'h0555, 16'h0066, 4, 1'b1);
    send_pkt(1'b0, 1'b0);
    checks++;
    if ({hops, e_max, e_min} !== {16'h0003, 16'h0555, 16'h0066}) begin
      errors++;
      $display("FAIL hb_worse got=%h/%h/%h exp=0003/0555/0066", hops, e_max, e_min);
    end
  endtask

  task automatic test_cha();
    mk_pkt(16'h2000, 16'h000C, 16'h0007, 16'h0000, 3, 1'b1);
    send_pkt(1'b0, 1'b0);
    checks++;
    if ({ch_ID, timeslot, e_max, hops} !== {16'h000C, 16'h0007, 16'h0555, 16'h0003}) begin
      errors++;
      $display("FAIL cha got=%h/%h/%h/%h exp=000c/0007/0555/0003", ch_ID, timeslot, e_max, hops);
    end
  endtask

  task automatic test_drops();
    mk_pkt(16'h1000, 16'h0002, 16'h0, 16'h0, 2, 1'b1);
    send_pkt(1'b0, 1'b0);
    checks++;
    if (drop_cnt !== 8'd1) begin errors++; $display("FAIL short_drop got=%0d exp=1", drop_cnt); end
    mk_pkt(16'h3000, 16'h0001, 16'h0002, 16'h0003, 4, 1'b1);
    send_pkt(1'b0, 1'b0);
    checks++;
    if (drop_cnt !== 8'd2) begin errors++; $display("FAIL unknown_drop got=%0d exp=2", drop_cnt); end
    mk_pkt(16'h1000, 16'h0004, 16'h0, 16'h0, 2, 1'b0);
    send_pkt(1'b0, 1'b0);
    mk_pkt(16'h2000, 16'h0011, 16'h0022, 16'h0, 3, 1'b1);
    send_pkt(1'b0, 1'b0);
    checks++;
    if ({drop_cnt, ch_ID, timeslot} !== {8'd3, 16'h0011, 16'h0022}) begin
      errors++;
      $display("FAIL abort_restart got=%0d/%h/%h exp=3/0011/0022", drop_cnt, ch_ID, timeslot);
    end
  endtask

  task automatic test_back_to_back();
    mk_pkt(16'h1000, 16'h0001, 16'h0AAA, 16'h0BBB, 4, 1'b1);
    send_pkt(1'b0, 1'b0);
    mk_pkt(16'h2000, 16'h0033, 16'h0044, 16'h0, 3, 1'b1);
    send_pkt(1'b0, 1'b0);
    checks++;
    if (last_stalls !== 1) begin
      errors++;
      $display("FAIL b2b_stall got=%0d exp=1", last_stalls);
    end
  endtask

  task automatic test_random();
    bit force_good = 1'b0;
    for (int k = 0; k < 80; k++) begin
      int sel, n, len;
      logic [3:0] t;
      logic [15:0] x;
      sel = $urandom_range(0, 9);
      if (force_good || sel < 5) t = (force_good && sel >= 5) ? 4'h2 : 4'h1;
      else if (sel < 9)          t = 4'h2;
      else                       t = 4'($urandom_range(3, 15));
      n = (t == 4'h1) ? NHB : (t == 4'h2) ? NCHA : int'($urandom_range(1, 5));
      len = n;
      if (!force_good && $urandom_range(0, 9) < 3) len = n + int'($urandom_range(0, 4)) - 2;
      if (len < 1) len = 1;
      pq.delete();
      pq.push_back({t, 12'($urandom)});
      for (int i = 1; i < len; i++)
        pq.push_back((i == 1) ? 16'($urandom_range(0, 6)) : 16'($urandom));
      if (CS && len >= 2 && (force_good || $urandom_range(0, 4) != 0)) begin
        x = '0;
        for (int i = 0; i < len - 1; i++) x ^= pq[i];
        pq[len-1] = x;
      end
      peop = force_good || ($urandom_range(0, 7) != 0);
      send_pkt(1'b1, 1'b0);
      force_good = !peop;
      if (peop && $urandom_range(0, 4) == 0) junk();
    end
  endtask

`ifdef RX_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] before;
    before = drop_cnt;
    mk_pkt(16'h1000, 16'h0000, 16'h0123, 16'h0456, 4, 1'b1);
    pq[pq.size()-1] = pq[pq.size()-1] ^ 16'h0100;
    send_pkt(1'b0, 1'b0);
    checks++;
    if (drop_cnt !== before + 8'd1) begin
      errors++;
      $display("FAIL bad_checksum got=%0d exp=%0d", drop_cnt, before + 8'd1);
    end
  endtask
`endif

  task automatic test_drop_sat();
    for (int k = 0; k < 300; k++) begin
      mk_pkt(16'h3000, 16'h0, 16'h0, 16'h0, 1, 1'b1);
      send_pkt(1'b0, 1'b0);
    end
    checks++;
    if (drop_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL drop_sat got=%h exp=ff", drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    pq.delete();
    pq.push_back(16'h1000);
    pq.push_back(16'h0002);
    peop = 1'b0;
    send_pkt(1'b0, 1'b1);
    #2 nrst = 1'b0;
    #1 check_reset_vals("reset_mid");
    m_emax = '0; m_emin = '0; m_hops = 16'hFFFF; m_ch = '0; m_ts = '0; m_drop = 0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    mk_pkt(16'h2000, 16'h0009, 16'h0005, 16'h0, 3, 1'b1);
    send_pkt(1'b0, 1'b0);
    checks++;
    if ({ch_ID, timeslot, drop_cnt, hops} !== {16'h0009, 16'h0005, 8'd0, 16'hFFFF}) begin
      errors++;
      $display("FAIL post_reset_cha got=%h/%h/%0d/%h exp=0009/0005/0/ffff", ch_ID, timeslot, drop_cnt, hops);
    end
  endtask

  task automatic test_pulse_count();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pulses !== m_commits) begin
      errors++;
      $display("FAIL en_MNI_pulses got=%0d exp=%0d", pulses, m_commits);
    end
  endtask

  initial begin
    test_reset();
    test_hops_sat();
    test_hb();
    test_cha();
    test_drops();
    test_back_to_back();
    test_random();
`ifdef RX_CHECKSUM_EN
    test_checksum();
`endif
    test_drop_sat();
    test_reset_mid();
    test_pulse_count();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t limit=2000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
